mem_access_unit: RTL

Load/store initiator that sits between the MEM stage of the 16-bit pipeline and `dataMemory`, driving that block's `memRead`/`memWrite`/`sByte`/`addr`/`wrData` side and consuming `dataOut`. It accepts one request at a time over a valid/ready handshake, sequences the memory strobes with registered outputs, and formats load results with byte select and sign/zero extension. Misaligned halfword accesses are trapped without touching memory.

---
 rtl/mem_access_pkg.sv | 16 +
 rtl/mem_access_unit_if.sv | 42 ++++
 rtl/mem_access_unit_load_formatter.sv | 29 ++
 rtl/mem_access_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store initiator: FSM encoding and bus widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_access_pkg;

  localparam int AW = 16;  // byte address width
  localparam int DW = 16;  // data width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle between the MEM stage, the load/store unit and dataMemory.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready on the request side, resp_valid/resp_ready on the response side.
// Ports: req_* request, resp_* response, memRead/memWrite/sByte/addr/wrData/dataOut memory side.
interface mem_access_unit_if #(
  parameter int AW = mem_access_pkg::AW,
  parameter int DW = mem_access_pkg::DW
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic          req_byte;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic          misalign_err;
  logic          memRead;
  logic          memWrite;
  logic          sByte;
  logic [AW-1:0] addr;
  logic [DW-1:0] wrData;
  logic [DW-1:0] dataOut;

  // The unit itself.
  modport slave (
    input  req_valid, req_we, req_byte, req_signed, req_addr, req_wdata,
    input  resp_ready, dataOut,
    output req_ready, resp_valid, resp_data, misalign_err,
    output memRead, memWrite, sByte, addr, wrData
  );

  // Pipeline plus memory, seen from the outside of the unit.
  modport master (
    output req_valid, req_we, req_byte, req_signed, req_addr, req_wdata,
    output resp_ready, dataOut,
    input  req_ready, resp_valid, resp_data, misalign_err,
    input  memRead, memWrite, sByte, addr, wrData
  );
endinterface

// File: rtl/mem_access_unit_load_formatter.sv
// Formats raw memory read data into a load result (byte select + sign/zero extension).
// Latency: combinational.
// Backpressure: none.
// Ports: dataOut raw halfword, addrLsb byte lane, isByte/isSigned access type, result formatted data.
module load_formatter
  import mem_access_pkg::*;
(
  input  logic [DW-1:0] dataOut,
  input  logic          addrLsb,
  input  logic          isByte,
  input  logic          isSigned,
  output logic [DW-1:0] result
);

  logic [7:0] selByte;

  always_comb begin
    // Little-endian: the odd byte sits in the upper lane of the aligned halfword.
    selByte = addrLsb ? dataOut[15:8] : dataOut[7:0];
    if (!isByte) begin
      result = dataOut;
    end else if (isSigned) begin
      result = {{(DW-8){selByte[7]}}, selByte};
    end else begin
      result = {{(DW-8){1'b0}}, selByte};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator between the MEM stage and dataMemory; traps misaligned halfwords.
// Latency: accept->resp_valid is 1 cycle (misaligned), 2 (store), 3 (load); all memory-side outputs registered.
// Backpressure: req_ready only in IDLE; response held in RESP until resp_ready, nothing queued.
// Ports: clk, rst (sync, active-low), bus (slave modport of mem_access_unit_if).
module mem_access_unit #(
  parameter int AW = mem_access_pkg::AW,
  parameter int DW = mem_access_pkg::DW
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_unit_if.slave bus
);
  import mem_access_pkg::*;

  state_t state, nextState;

  // Request fields still needed after the accept edge. Address and store
  // data are captured directly into addrQ/wrDataQ, which already hold them
  // for the ISSUE cycle.
  logic capWe, capByte, capSigned, capLsb;

  logic          memReadQ, memWriteQ, sByteQ;
  logic [AW-1:0] addrQ;
  logic [DW-1:0] wrDataQ;
  logic          respValidQ, misalignQ;
  logic [DW-1:0] respDataQ;

  logic          memReadNxt, memWriteNxt, sByteNxt;
  logic [AW-1:0] addrNxt;
  logic [DW-1:0] wrDataNxt;
  logic          respValidNxt, misalignNxt;
  logic [DW-1:0] respDataNxt;

  logic          accept;
  logic          misaligned;
  logic [DW-1:0] fmtResult;

  assign accept     = (state == IDLE) && bus.req_valid;
  assign misaligned = !bus.req_byte && bus.req_addr[0];

  load_formatter u_fmt (
    .dataOut  (bus.dataOut),
    .addrLsb  (capLsb),
    .isByte   (capByte),
    .isSigned (capSigned),
    .result   (fmtResult)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.req_valid) nextState = misaligned ? RESP : ISSUE;
      ISSUE:   nextState = capWe ? RESP : WAIT;
      WAIT:    nextState = RESP;
      RESP:    if (bus.resp_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs. Strobes are set on
  // the accept edge so they are high exactly during ISSUE.
  always_comb begin
    memReadNxt   = 1'b0;
    memWriteNxt  = 1'b0;
    sByteNxt     = 1'b0;
    addrNxt      = addrQ;
    wrDataNxt    = wrDataQ;
    respValidNxt = (nextState == RESP);
    respDataNxt  = respDataQ;
    misalignNxt  = misalignQ;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misaligned) begin
            respDataNxt = '0;
            misalignNxt = 1'b1;
          end else if (bus.req_we) begin
            memWriteNxt = 1'b1;
            sByteNxt    = bus.req_byte;
            addrNxt     = bus.req_addr;
            wrDataNxt   = bus.req_wdata;
          end else begin
            memReadNxt = 1'b1;
            // Loads always fetch the aligned halfword; the formatter picks the lane.
            addrNxt    = {bus.req_addr[AW-1:1], 1'b0};
          end
        end
      end
      ISSUE: begin
        if (capWe) begin
          respDataNxt = '0;
          misalignNxt = 1'b0;
        end
      end
      WAIT: begin
        respDataNxt = fmtResult;
        misalignNxt = 1'b0;
      end
      RESP: begin
        // resp_data stays put after the handshake; the error flag is cleared
        // so it never lingers into the next request.
        if (bus.resp_ready) misalignNxt = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      capWe      <= 1'b0;
      capByte    <= 1'b0;
      capSigned  <= 1'b0;
      capLsb     <= 1'b0;
      memReadQ   <= 1'b0;
      memWriteQ  <= 1'b0;
      sByteQ     <= 1'b0;
      addrQ      <= '0;
      wrDataQ    <= '0;
      respValidQ <= 1'b0;
      respDataQ  <= '0;
      misalignQ  <= 1'b0;
    end else begin
      if (accept) begin
        capWe     <= bus.req_we;
        capByte   <= bus.req_byte;
        capSigned <= bus.req_signed;
        capLsb    <= bus.req_addr[0];
      end
      memReadQ   <= memReadNxt;
      memWriteQ  <= memWriteNxt;
      sByteQ     <= sByteNxt;
      addrQ      <= addrNxt;
      wrDataQ    <= wrDataNxt;
      respValidQ <= respValidNxt;
      respDataQ  <= respDataNxt;
      misalignQ  <= misalignNxt;
    end
  end

  assign bus.req_ready    = (state == IDLE);
  assign bus.memRead      = memReadQ;
  assign bus.memWrite     = memWriteQ;
  assign bus.sByte        = sByteQ;
  assign bus.addr         = addrQ;
  assign bus.wrData       = wrDataQ;
  assign bus.resp_valid   = respValidQ;
  assign bus.resp_data    = respDataQ;
  assign bus.misalign_err = misalignQ;

endmodule
